// File: rtl/l2_snoop_responder_if.sv
// L1<->L2 bus bundle: request/response channel, external snoop injection and snoop-to-L1 channel.
interface l2_snoop_responder_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_op;
    logic [ADDR_W-1:0] rsp_addr;

    logic              ext_snp_valid;
    logic              ext_snp_ready;
    logic              ext_snp_op;
    logic [ADDR_W-1:0] ext_snp_addr;

    logic              snp_valid;
    logic              snp_ready;
    logic [3:0]        snp_cmd;
    logic [ADDR_W-1:0] snp_addr;

    // Responder side
    modport slave (
        input  req_valid, req_op, req_addr, rsp_ready,
        input  ext_snp_valid, ext_snp_op, ext_snp_addr, snp_ready,
        output req_ready, rsp_valid, rsp_op, rsp_addr,
        output ext_snp_ready, snp_valid, snp_cmd, snp_addr
    );

    // L1 / driver side
    modport master (
        output req_valid, req_op, req_addr, rsp_ready,
        output ext_snp_valid, ext_snp_op, ext_snp_addr, snp_ready,
        input  req_ready, rsp_valid, rsp_op, rsp_addr,
        input  ext_snp_ready, snp_valid, snp_cmd, snp_addr
    );
endinterface

// File: rtl/l2_snoop_responder.sv
// L2 responder for the L1 data-cache protocol: fixed-latency request responses plus an ordered snoop queue.
// Optional per-op statistics counters are enabled with `define L2_STATS_EN.
module l2_snoop_responder #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned OFFSET_BITS = 6,
    parameter int unsigned RESP_LAT    = 3,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    l2_snoop_responder_if.slave   bus
`ifdef L2_STATS_EN
    ,
    output logic [15:0]           rd_cnt,
    output logic [15:0]           wr_cnt,
    output logic [15:0]           rfo_cnt,
    output logic [15:0]           ev_cnt,
    output logic [15:0]           inv_cnt,
    output logic [15:0]           drq_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned LAT_W = 4;

    localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFFSET_BITS;
    localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(RESP_LAT - 1);
    localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [LAT_W-1:0]  r_lat_cnt;
    logic [LAT_W-1:0]  w_lat_cnt_nxt;
    logic              w_capture;
    logic [1:0]        r_req_op;
    logic [ADDR_W-1:0] r_req_line;

    logic              r_fifo_op   [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_fifo_line [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_conflict;
    logic              w_snp_valid;
    logic              w_head_op;
    logic [ADDR_W-1:0] w_head_line;

    // Request FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_lat_cnt  <= '0;
            r_req_op   <= '0;
            r_req_line <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lat_cnt <= w_lat_cnt_nxt;
            if (w_capture) begin
                r_req_op   <= bus.req_op;
                r_req_line <= bus.req_addr & LINE_MASK;
            end
        end
    end

    // Request FSM: next state
    always_comb begin
        w_state_nxt   = r_state;
        w_lat_cnt_nxt = r_lat_cnt;
        w_capture     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_capture     = 1'b1;
                    w_lat_cnt_nxt = LAT_INIT;
                    w_state_nxt   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt - LAT_W'(1);
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == FIFO_FULL);
    assign w_head_op   = r_fifo_op[r_rd_ptr];
    assign w_head_line = r_fifo_line[r_rd_ptr];
    // A snoop to the line of the outstanding request waits until that response completes
    assign w_conflict  = (r_state != S_IDLE) && (w_head_line == r_req_line);
    assign w_snp_valid = !w_empty && !w_conflict;
    assign w_push      = bus.ext_snp_valid && !w_full;
    assign w_pop       = w_snp_valid && bus.snp_ready;

    // Snoop queue storage and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_op[i]   <= 1'b0;
                r_fifo_line[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_op[r_wr_ptr]   <= bus.ext_snp_op;
                r_fifo_line[r_wr_ptr] <= bus.ext_snp_addr & LINE_MASK;
                r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.req_ready     = (r_state == S_IDLE);
    assign bus.rsp_valid     = (r_state == S_RESP);
    assign bus.rsp_op        = r_req_op;
    assign bus.rsp_addr      = r_req_line;
    assign bus.ext_snp_ready = !w_full;
    assign bus.snp_valid     = w_snp_valid;
    assign bus.snp_cmd       = w_empty ? 4'd0 : (w_head_op ? 4'd4 : 4'd3);
    assign bus.snp_addr      = w_empty ? '0 : w_head_line;

`ifdef L2_STATS_EN
    logic [15:0] r_rd_cnt;
    logic [15:0] r_wr_cnt;
    logic [15:0] r_rfo_cnt;
    logic [15:0] r_ev_cnt;
    logic [15:0] r_inv_cnt;
    logic [15:0] r_drq_cnt;

    // Wrapping counters of accepted requests and popped snoops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_rfo_cnt <= '0;
            r_ev_cnt  <= '0;
            r_inv_cnt <= '0;
            r_drq_cnt <= '0;
        end else begin
            if (w_capture) begin
                case (bus.req_op)
                    2'd0:    r_rd_cnt  <= r_rd_cnt + 16'd1;
                    2'd1:    r_wr_cnt  <= r_wr_cnt + 16'd1;
                    2'd2:    r_rfo_cnt <= r_rfo_cnt + 16'd1;
                    default: r_ev_cnt  <= r_ev_cnt + 16'd1;
                endcase
            end
            if (w_pop) begin
                if (w_head_op) r_drq_cnt <= r_drq_cnt + 16'd1;
                else           r_inv_cnt <= r_inv_cnt + 16'd1;
            end
        end
    end

    assign rd_cnt  = r_rd_cnt;
    assign wr_cnt  = r_wr_cnt;
    assign rfo_cnt = r_rfo_cnt;
    assign ev_cnt  = r_ev_cnt;
    assign inv_cnt = r_inv_cnt;
    assign drq_cnt = r_drq_cnt;

    final begin
        $display("l2_snoop_responder stats: rd=%0d wr=%0d rfo=%0d ev=%0d inv=%0d drq=%0d",
                 r_rd_cnt, r_wr_cnt, r_rfo_cnt, r_ev_cnt, r_inv_cnt, r_drq_cnt);
    end
`endif

endmodule

// File: tb/tb_l2_snoop_responder.sv
// Self-checking bench for l2_snoop_responder: request vector table, snoop queue and hazard/reset sequences.
`timescale 1ns/1ps
module tb_l2_snoop_responder;

    localparam int unsigned AW    = 32;
    localparam int unsigned LAT   = 3;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] LMASK = 32'hFFFF_FFC0;

    logic clk;
    logic rst_n;

    l2_snoop_responder_if #(.ADDR_W(AW)) bus ();

`ifdef L2_STATS_EN
    logic [15:0] rd_cnt, wr_cnt, rfo_cnt, ev_cnt, inv_cnt, drq_cnt;
`endif

    l2_snoop_responder #(
        .ADDR_W(AW), .OFFSET_BITS(6), .RESP_LAT(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef L2_STATS_EN
        ,
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .rfo_cnt(rfo_cnt),
        .ev_cnt(ev_cnt), .inv_cnt(inv_cnt), .drq_cnt(drq_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed { logic [1:0] op; logic [31:0] addr; } rsp_exp_t;
    typedef struct packed { logic [3:0] cmd; logic [31:0] addr; } snp_exp_t;
    rsp_exp_t rsp_q[$];
    snp_exp_t snp_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        int          delay;
        logic [1:0]  exp_op;
        logic [31:0] exp_addr;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One request: accept, measure latency, optional backpressure, handshake
    task automatic do_req(input logic [1:0] op, input logic [31:0] addr, input int delay,
                          input logic [1:0] exp_op, input logic [31:0] exp_addr);
        int lat = -1;
        int busy_viol = 0;
        rsp_exp_t e;
        logic [1:0]  snap_op;
        logic [31:0] snap_addr;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        rsp_q.push_back('{op: exp_op, addr: exp_addr});
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) bus.req_valid = 1'b0;
            if (bus.rsp_valid) begin
                lat = k;
                break;
            end
            if (bus.req_ready) busy_viol++;
        end
        chk("rsp_latency", 64'(lat), 64'(LAT));
        chk("req_ready_busy", 64'(busy_viol), 64'd0);
        snap_op   = bus.rsp_op;
        snap_addr = bus.rsp_addr;
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            chk("rsp_hold", 64'({bus.req_ready, bus.rsp_valid, bus.rsp_op, bus.rsp_addr}),
                64'({1'b0, 1'b1, snap_op, snap_addr}));
        end
        e = rsp_q.pop_front();
        chk("rsp_op", 64'(bus.rsp_op), 64'(e.op));
        chk("rsp_addr", 64'(bus.rsp_addr), 64'(e.addr));
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("req_ready_after", 64'({bus.req_ready, bus.rsp_valid}), 64'(2'b10));
    endtask

    task automatic push_snoop(input logic op, input logic [31:0] addr, input logic exp_accept);
        @(negedge clk);
        bus.ext_snp_valid = 1'b1;
        bus.ext_snp_op    = op;
        bus.ext_snp_addr  = addr;
        chk("ext_snp_ready", 64'(bus.ext_snp_ready), 64'(exp_accept));
        if (exp_accept) snp_q.push_back('{cmd: (op ? 4'd4 : 4'd3), addr: addr & LMASK});
        @(posedge clk);
        #1 bus.ext_snp_valid = 1'b0;
    endtask

    task automatic drain_snoops(input int n);
        snp_exp_t e;
        bool_loop: for (int i = 0; i < n; i++) begin
            int waited = 0;
            @(negedge clk);
            bus.snp_ready = 1'b1;
            while (!bus.snp_valid && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            if (!bus.snp_valid) begin
                chk("snp_timeout", 64'(bus.snp_valid), 64'd1);
                break;
            end
            e = snp_q.pop_front();
            chk("snp_cmd", 64'(bus.snp_cmd), 64'(e.cmd));
            chk("snp_addr", 64'(bus.snp_addr), 64'(e.addr));
            @(posedge clk);
        end
        @(negedge clk);
        bus.snp_ready = 1'b0;
    endtask

    initial begin
        int viol;
        int rsp_seen;
        int snp_seen;
        int lat;
        snp_exp_t se;

        vecs[0] = '{op: 2'd0, addr: 32'h0000_1234, delay: 0, exp_op: 2'd0, exp_addr: 32'h0000_1200};
        vecs[1] = '{op: 2'd1, addr: 32'hDEAD_BEEF, delay: 5, exp_op: 2'd1, exp_addr: 32'hDEAD_BEC0};
        vecs[2] = '{op: 2'd2, addr: 32'h0000_003F, delay: 1, exp_op: 2'd2, exp_addr: 32'h0000_0000};
        vecs[3] = '{op: 2'd3, addr: 32'hFFFF_FFFF, delay: 0, exp_op: 2'd3, exp_addr: 32'hFFFF_FFC0};
        vecs[4] = '{op: 2'd0, addr: 32'h0000_0040, delay: 2, exp_op: 2'd0, exp_addr: 32'h0000_0040};
        vecs[5] = '{op: 2'd3, addr: 32'h1234_5678, delay: 0, exp_op: 2'd3, exp_addr: 32'h1234_5640};

        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_addr = '0; bus.rsp_ready = 1'b0;
        bus.ext_snp_valid = 1'b0; bus.ext_snp_op = 1'b0; bus.ext_snp_addr = '0; bus.snp_ready = 1'b0;
        rst_n = 1'b0;
        #12;
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_snp_valid", 64'(bus.snp_valid), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_ext_ready", 64'(bus.ext_snp_ready), 64'd1);
        chk("rst_rsp_op", 64'(bus.rsp_op), 64'd0);
        chk("rst_rsp_addr", 64'(bus.rsp_addr), 64'd0);
        chk("rst_snp_cmd", 64'(bus.snp_cmd), 64'd0);
        chk("rst_snp_addr", 64'(bus.snp_addr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) do_req(vecs[i].op, vecs[i].addr, vecs[i].delay, vecs[i].exp_op, vecs[i].exp_addr);

        // Fill the queue, refuse a fifth push, then drain in order
        push_snoop(1'b0, 32'h0000_0040, 1'b1);
        push_snoop(1'b0, 32'h0000_0080, 1'b1);
        push_snoop(1'b0, 32'h0000_00C0, 1'b1);
        push_snoop(1'b0, 32'h0000_0100, 1'b1);
        push_snoop(1'b0, 32'h0000_0140, 1'b0);
        drain_snoops(4);
        chk("snp_empty", 64'({bus.snp_valid, bus.ext_snp_ready}), 64'(2'b01));

        // Simultaneous push and pop
        push_snoop(1'b1, 32'h0000_7000, 1'b1);
        @(negedge clk);
        bus.snp_ready     = 1'b1;
        bus.ext_snp_valid = 1'b1;
        bus.ext_snp_op    = 1'b1;
        bus.ext_snp_addr  = 32'h0000_7048;
        se = snp_q.pop_front();
        chk("pp_snp_valid", 64'(bus.snp_valid), 64'd1);
        chk("pp_snp_addr", 64'(bus.snp_addr), 64'(se.addr));
        snp_q.push_back('{cmd: 4'd4, addr: 32'h0000_7040});
        @(posedge clk);
        #1 bus.ext_snp_valid = 1'b0;
        bus.snp_ready = 1'b0;
        drain_snoops(1);
        chk("pp_empty", 64'(bus.snp_valid), 64'd0);

        // Hazard: snoop to the in-flight line is held until the response handshake
        @(negedge clk);
        bus.snp_ready = 1'b1;
        bus.req_valid = 1'b1; bus.req_op = 2'd2; bus.req_addr = 32'h0000_2000;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        bus.ext_snp_valid = 1'b1; bus.ext_snp_op = 1'b1; bus.ext_snp_addr = 32'h0000_2010;
        @(posedge clk);
        #1 bus.ext_snp_valid = 1'b0;
        viol = 0;
        lat  = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.snp_valid) viol++;
            if (bus.rsp_valid) begin
                lat = k;
                break;
            end
        end
        chk("hz_rsp_seen", 64'(lat >= 0), 64'd1);
        for (int d = 0; d < 2; d++) begin
            @(negedge clk);
            if (bus.snp_valid) viol++;
        end
        chk("hz_hold", 64'(viol), 64'd0);
        chk("hz_rsp", 64'({bus.rsp_op, bus.rsp_addr}), 64'({2'd2, 32'h0000_2000}));
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("hz_release", 64'({bus.snp_valid, bus.snp_cmd, bus.snp_addr}), 64'({1'b1, 4'd4, 32'h0000_2000}));
        @(posedge clk);
        @(negedge clk);
        bus.snp_ready = 1'b0;
        chk("hz_popped", 64'(bus.snp_valid), 64'd0);

        // Reset during WAIT with two snoops queued
        push_snoop(1'b0, 32'h0000_0300, 1'b1);
        push_snoop(1'b1, 32'h0000_0340, 1'b1);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 2'd0; bus.req_addr = 32'h0000_0500;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("mid_rst_snp_valid", 64'(bus.snp_valid), 64'd0);
        chk("mid_rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("mid_rst_ext_ready", 64'(bus.ext_snp_ready), 64'd1);
        snp_q.delete();
        rsp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        bus.snp_ready = 1'b1;
        rsp_seen = 0;
        snp_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) rsp_seen++;
            if (bus.snp_valid) snp_seen++;
        end
        chk("post_rst_no_rsp", 64'(rsp_seen), 64'd0);
        chk("post_rst_no_snp", 64'(snp_seen), 64'd0);
        bus.rsp_ready = 1'b0;
        bus.snp_ready = 1'b0;

        do_req(2'd0, 32'h0000_9010, 1, 2'd0, 32'h0000_9000);

`ifdef L2_STATS_EN
        do_req(2'd0, 32'h0000_A000, 0, 2'd0, 32'h0000_A000);
        do_req(2'd1, 32'h0000_A044, 0, 2'd1, 32'h0000_A040);
        do_req(2'd3, 32'h0000_A0FF, 0, 2'd3, 32'h0000_A0C0);
        push_snoop(1'b0, 32'h0000_B000, 1'b1);
        push_snoop(1'b0, 32'h0000_B040, 1'b1);
        push_snoop(1'b0, 32'h0000_B080, 1'b1);
        drain_snoops(3);
        chk("st_rd", 64'(rd_cnt), 64'd2);
        chk("st_wr", 64'(wr_cnt), 64'd1);
        chk("st_rfo", 64'(rfo_cnt), 64'd0);
        chk("st_ev", 64'(ev_cnt), 64'd1);
        chk("st_inv", 64'(inv_cnt), 64'd3);
        chk("st_drq", 64'(drq_cnt), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/l2_snoop_responder.md
Name: l2_snoop_responder

Overview:
- Models the L2 side of the L1 data-cache protocol.
- Accepts L1-to-L2 bus requests (READ, WRITE, RFO, EVICT) and returns a fixed-latency response for each.
- Queues externally injected L2 snoops and issues them to L1 as trace-coded commands 3 (L2_INVAL) and 4 (L2_DATA_RQ).
- Sits between the L1 cache model and the testbench or trace driver.

Parameters:
- ADDR_W, 32, address width.
- OFFSET_BITS, 6, line-offset bits cleared in all returned addresses.
- RESP_LAT, 3, cycles from request acceptance to rsp_valid; legal range 1..15.
- FIFO_DEPTH, 4, snoop queue entries; power of 2, at least 2.

Ports:
- clk, in, 1, clock; all state changes on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- req_valid, in, 1, L1 request present.
- req_ready, out, 1, responder can accept a request.
- req_op, in, 2, request type: 0 READ, 1 WRITE, 2 RFO, 3 EVICT.
- req_addr, in, ADDR_W, request byte address.
- rsp_valid, out, 1, response present.
- rsp_ready, in, 1, L1 accepts the response.
- rsp_op, out, 2, echo of the accepted req_op.
- rsp_addr, out, ADDR_W, line address of the request, offset bits zeroed.
- ext_snp_valid, in, 1, snoop injection present.
- ext_snp_ready, out, 1, snoop queue not full.
- ext_snp_op, in, 1, snoop type: 0 invalidate, 1 data request.
- ext_snp_addr, in, ADDR_W, snoop address.
- snp_valid, out, 1, snoop command to L1 present.
- snp_ready, in, 1, L1 accepts the snoop.
- snp_cmd, out, 4, trace command code: 3 for invalidate, 4 for data request.
- snp_addr, out, ADDR_W, snoop line address, offset bits zeroed.

Behaviour:
- Reset: asynchronous, active-low (rst_n=0), applied immediately regardless of clk.
  - Outputs: rsp_valid=0, snp_valid=0, rsp_op=0, rsp_addr=0, snp_cmd=0, snp_addr=0, req_ready=1, ext_snp_ready=1.
  - FSM goes to IDLE; FIFO is emptied; counters are cleared.
  - Reset mid-transaction discards the in-flight request and all queued snoops. No response is issued afterwards.
- Request FSM, states IDLE, WAIT, RESP:
  - req_ready = (state==IDLE).
  - IDLE: on req_valid & req_ready, capture op and line address, load lat_cnt=RESP_LAT-1, go to WAIT.
  - WAIT: if lat_cnt==0 go to RESP, else decrement lat_cnt.
  - RESP: rsp_valid=1. On rsp_ready, go to IDLE.
  - Timing: acceptance at edge N gives rsp_valid high from edge N+RESP_LAT.
  - RESP_LAT=1: WAIT lasts a single cycle.
  - rsp_valid, rsp_op and rsp_addr stay stable until the handshake. The earliest next acceptance is the cycle after the handshake, so there is no back-to-back overlap.
- Snoop FIFO:
  - ext_snp_ready = !full.
  - Push on ext_snp_valid & ext_snp_ready.
  - Pop on snp_valid & snp_ready.
  - Push and pop in the same cycle are both honoured, and the count is unchanged.
  - Full: push is refused and the queue contents are unchanged. Push and pop in the same cycle while full is not possible, because ext_snp_ready=0 (no bypass).
  - Empty: snp_valid=0.
  - Read and write pointers wrap modulo FIFO_DEPTH. An occupancy counter of width clog2(FIFO_DEPTH)+1 distinguishes full from empty.
- Ordering hazard:
  - snp_valid = !empty & !conflict.
  - conflict = (state != IDLE) & (head line address == captured request line address).
  - A conflicting snoop is held, not dropped, and is released the cycle after the response handshake.
  - Only the head entry is checked. There is no reordering.
- Snoop outputs: snp_cmd and snp_addr are driven combinationally from the head entry and are stable while snp_valid=1 and snp_ready=0.

Optional Feature:
- Macro: L2_STATS_EN.
- Defined: 16-bit wrapping counters rd_cnt, wr_cnt, rfo_cnt, ev_cnt count accepted requests by op, and inv_cnt, drq_cnt count popped snoops by type. All six are exposed as extra output ports. A final block prints them in one line.
- Undefined: no counters, no extra ports, no final block. The interface matches the list above exactly.

Test Plan:
- Reset then READ: req_op=0, addr=0x0000_1234, RESP_LAT=3, accepted at edge 1 → rsp_valid high from edge 4 with rsp_op=0 and rsp_addr=0x0000_1200; req_ready=0 during edges 1-4.
- Response backpressure: rsp_ready held 0 for 5 cycles → rsp_valid, rsp_op and rsp_addr stay constant and req_ready stays 0; on rsp_ready=1, req_ready=1 on the next cycle.
- Snoop fill: push 4 invalidates (addr 0x40, 0x80, 0xC0, 0x100) with snp_ready=0 → ext_snp_ready=0 after the 4th push and a 5th push is refused; snp_ready=1 then pops in order with snp_cmd=3 each time.
- Hazard: RFO to 0x2000 in flight and a data request to 0x2010 queued → snp_valid=0 until the response handshake, then snp_valid=1 with snp_cmd=4 and snp_addr=0x2000.
- Reset mid-WAIT: rst_n pulsed low during WAIT with 2 snoops queued → immediately rsp_valid=0, snp_valid=0, req_ready=1, and no response appears afterwards.
- With L2_STATS_EN: 2 READ, 1 WRITE, 1 EVICT, 3 invalidate snoops popped → rd_cnt=2, wr_cnt=1, ev_cnt=1, inv_cnt=3, rfo_cnt=0, drq_cnt=0.
